// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// State encoding, settle counter width and legal settle bounds.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    localparam int CNT_W      = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    // Out-of-range settle requests are clamped so the timer always expires.
    function automatic logic [CNT_W-1:0] settle_load(input int cycles);
        if (cycles < SETTLE_MIN) return CNT_W'(SETTLE_MIN);
        if (cycles > SETTLE_MAX) return CNT_W'(SETTLE_MAX);
        return CNT_W'(cycles);
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Request and result port of the mux scan controller (start/mask in, word out on valid/ready).
// The parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_if;

    logic       start;
    logic [3:0] ch_mask;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic       ready;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;

    modport master (
        input  start,
        input  ch_mask,
        input  ready,
        output busy,
        output data,
        output valid,
        output parity
    );

    modport slave (
        output start,
        output ch_mask,
        output ready,
        input  busy,
        input  data,
        input  valid,
        input  parity
    );
`else
    modport master (
        input  start,
        input  ch_mask,
        input  ready,
        output busy,
        output data,
        output valid
    );

    modport slave (
        output start,
        output ch_mask,
        output ready,
        input  busy,
        input  data,
        input  valid
    );
`endif

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; expire is high during the cycle whose closing edge ends the settle window.
// A load on the expiring edge restarts the window for the next channel.
module settle_timer
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the 4:1 mux select over the enabled channels, settles, samples, and
// presents the assembled word on a valid/ready port. Parity output: MUX_SCAN_PARITY_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start; select lines and data word held
// ST_SETTLE  | channel selected, settle timer running, sample on expiry
// ST_OUT     | word complete; valid held until ready
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.master scan,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

    state_e     state;
    logic [1:0] sel;
    logic [3:0] mask_q;
    logic [3:0] shadow;
    logic [3:0] shadow_upd;
    logic [3:0] data_q;
    logic [3:0] data_nxt;
    logic       valid_q;
    logic       busy_q;
    logic [1:0] first_idx;
    logic [1:0] next_idx;
    logic       next_found;
    logic       accept;
    logic       accept_scan;
    logic       last_sample;
    logic       data_load;
    logic       tmr_load;
    logic       tmr_expire;

    // Lowest enabled channel of the incoming request.
    always_comb begin
        first_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (scan.ch_mask[k]) first_idx = 2'(k);
        end
    end

    // Next enabled channel above the current select in the latched mask.
    always_comb begin
        next_found = 1'b0;
        next_idx   = sel;
        for (int k = 3; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(sel))) begin
                next_found = 1'b1;
                next_idx   = 2'(k);
            end
        end
    end

    always_comb begin
        shadow_upd      = shadow;
        shadow_upd[sel] = mux_out;
    end

    assign accept      = (state == ST_IDLE) && scan.start;
    assign accept_scan = accept && (scan.ch_mask != 4'd0);
    assign last_sample = (state == ST_SETTLE) && tmr_expire && !next_found;
    assign tmr_load    = accept_scan || ((state == ST_SETTLE) && tmr_expire && next_found);
    // An empty request publishes an all-zero word without scanning.
    assign data_load   = (accept && !accept_scan) || last_sample;
    assign data_nxt    = last_sample ? shadow_upd : 4'd0;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= 2'd0;
            mask_q  <= 4'd0;
            shadow  <= 4'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (data_load) data_q <= data_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (accept_scan) begin
                            mask_q <= scan.ch_mask;
                            sel    <= first_idx;
                            shadow <= 4'd0;
                            state  <= ST_SETTLE;
                        end else begin
                            state  <= ST_OUT;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr_expire) begin
                        shadow <= shadow_upd;
                        if (next_found) begin
                            sel <= next_idx;
                        end else begin
                            valid_q <= 1'b1;
                            state   <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    // Empty-mask entry arrives with valid low; it rises one edge later.
                    if (valid_q && scan.ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (data_load) begin
            parity_q <= ^data_nxt;
        end
    end

    assign scan.parity = parity_q;
`endif

    assign s1         = sel[1];
    assign s0         = sel[0];
    assign scan.data  = data_q;
    assign scan.valid = valid_q;
    assign scan.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: vector table on a SETTLE_CYCLES=1 instance plus
// hand-written sparse, backpressure, back-to-back and reset sequences.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ivec is {i0,i1,i2,i3}, i.e. i0 is the MSB of the vector
    logic [3:0] ivec;
    logic       i0, i1, i2, i3;
    assign {i0, i1, i2, i3} = ivec;

    logic s1_a, s0_a, mo_a;
    logic s1_b, s0_b, mo_b;

    function automatic logic mux4(input logic a, input logic b, input logic c, input logic d,
                                  input logic [1:0] s);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    assign mo_a = mux4(i0, i1, i2, i3, {s1_a, s0_a});
    assign mo_b = mux4(i0, i1, i2, i3, {s1_b, s0_b});

    mux_scan_if if_a ();
    mux_scan_if if_b ();

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan    (if_a),
        .mux_out (mo_a),
        .s1      (s1_a),
        .s0      (s0_a)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(3)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .scan    (if_b),
        .mux_out (mo_b),
        .s1      (s1_b),
        .s0      (s0_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a scan on instance A and waits (bounded) for valid.
    task automatic do_scan(input string tag, input logic [3:0] iv, input logic [3:0] m,
                           input logic [3:0] exp_d, input int exp_lat);
        logic [3:0] prev;
        int         lat;
        logic       hold_ok;
        prev    = if_a.data;
        hold_ok = 1'b1;
        ivec          = iv;
        if_a.ch_mask  = m;
        if_a.start    = 1'b1;
        @(posedge clk); #1;
        if_a.start    = 1'b0;
        if_a.ch_mask  = ~m;
        check({tag, "_busy"}, 32'(if_a.busy), 32'd1);
        lat = 0;
        while (!if_a.valid && lat < 64) begin
            if (m != 4'd0 && if_a.data !== prev) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, 32'(if_a.data), 32'(exp_d));
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    endtask

    typedef struct {
        logic [3:0] ivec;
        logic [3:0] mask;
        logic [3:0] exp_data;
        int         exp_lat;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic       ok;
        int         lat;
        logic [1:0] exp_sel;

        vecs[0] = '{4'b1010, 4'b1111, 4'b0101, 4, 2'd3};
        vecs[1] = '{4'b1111, 4'b0110, 4'b0110, 2, 2'd2};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0000, 1, 2'd2};
        vecs[3] = '{4'b0101, 4'b1001, 4'b1000, 2, 2'd3};
        vecs[4] = '{4'b0110, 4'b0001, 4'b0000, 1, 2'd0};
        vecs[5] = '{4'b0001, 4'b1000, 4'b1000, 1, 2'd3};
        vecs[6] = '{4'b1101, 4'b1110, 4'b1010, 3, 2'd3};
        vecs[7] = '{4'b1110, 4'b1111, 4'b0111, 4, 2'd3};
        vecs[8] = '{4'b1100, 4'b1111, 4'b0011, 4, 2'd3};

        ivec = 4'b0000;
        if_a.start = 1'b0; if_a.ch_mask = 4'd0; if_a.ready = 1'b1;
        if_b.start = 1'b0; if_b.ch_mask = 4'd0; if_b.ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", 32'({s1_a, s0_a}), 32'd0);
        check("rst_data", 32'(if_a.data), 32'd0);
        check("rst_valid", 32'(if_a.valid), 32'd0);
        check("rst_busy", 32'(if_a.busy), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
        check("rst_parity", 32'(if_a.parity), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: ready held high, so valid must last exactly one cycle.
        for (int v = 0; v < 9; v++) begin
            do_scan($sformatf("v%0d", v), vecs[v].ivec, vecs[v].mask, vecs[v].exp_data,
                    vecs[v].exp_lat);
            check($sformatf("v%0d_sel", v), 32'({s1_a, s0_a}), 32'(vecs[v].exp_sel));
`ifdef MUX_SCAN_PARITY_EN
            check($sformatf("v%0d_parity", v), 32'(if_a.parity), 32'(^vecs[v].exp_data));
`endif
            @(posedge clk); #1;
            check($sformatf("v%0d_valid_drop", v), 32'(if_a.valid), 32'd0);
            check($sformatf("v%0d_idle", v), 32'(if_a.busy), 32'd0);
        end

        // Sparse mask on the SETTLE_CYCLES=3 instance.
        ivec = 4'b1111;
        if_b.ch_mask = 4'b1010;
        if_b.start = 1'b1;
        @(posedge clk); #1;
        if_b.start = 1'b0;
        if_b.ch_mask = 4'b0101;
        ok = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_sel = (t < 3) ? 2'd1 : 2'd3;
            if ({s1_b, s0_b} !== exp_sel || if_b.valid !== 1'b0) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("sparse_timeline", 32'(ok), 32'd1);
        check("sparse_valid_e6", 32'(if_b.valid), 32'd1);
        check("sparse_data", 32'(if_b.data), 32'b1010);
        @(posedge clk); #1;
        check("sparse_valid_drop", 32'(if_b.valid), 32'd0);

        // Backpressure: hold for 5 cycles, stray start ignored, then handshake.
        if_a.ready = 1'b0;
        do_scan("bp", 4'b1010, 4'b1111, 4'b0101, 4);
        ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            if (if_a.valid !== 1'b1 || if_a.data !== 4'b0101) ok = 1'b0;
            if_a.start   = (h == 1);
            if_a.ch_mask = 4'b0001;
            @(posedge clk); #1;
        end
        if_a.start = 1'b0;
        check("bp_hold", 32'(ok), 32'd1);
        check("bp_still_valid", 32'(if_a.valid), 32'd1);
        if_a.ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(if_a.valid), 32'd0);
        check("bp_idle", 32'(if_a.busy), 32'd0);

        // Back-to-back: start in the cycle right after the handshake edge.
        do_scan("b2b", 4'b1010, 4'b0001, 4'b0001, 1);
        check("b2b_sel", 32'({s1_a, s0_a}), 32'd0);
        @(posedge clk); #1;

        // Reset two edges into a full scan.
        ivec = 4'b1010;
        if_a.ch_mask = 4'b1111;
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_sel", 32'({s1_a, s0_a}), 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_sel", 32'({s1_a, s0_a}), 32'd0);
        check("abort_data", 32'(if_a.data), 32'd0);
        check("abort_valid", 32'(if_a.valid), 32'd0);
        check("abort_busy", 32'(if_a.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_scan("clean", 4'b0110, 4'b1111, 4'b0110, 4);
        @(posedge clk); #1;
        check("clean_valid_drop", 32'(if_a.valid), 32'd0);

        // Bounded wait on the idle instance: no spurious valid.
        lat = 0;
        while (!if_a.valid && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        check("quiet_idle", lat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
